sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester SRAM bus arbiter with in-order ID return FIFO (optional macro: ARB_ROUND_ROBIN_EN)
module sram_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_req,
  input  logic [70:0]              inst_cmd,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  output logic [31:0]              inst_rdata,
  input  logic                     data_req,
  input  logic [70:0]              data_cmd,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic [31:0]              data_rdata,
  output logic                     bus_req,
  output logic [70:0]              bus_cmd,
  input  logic                     bus_addr_ok,
  input  logic                     bus_data_ok,
  input  logic [31:0]              bus_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            full;
  logic            grant_data;
  logic            tie_data;
  logic            hs;
  logic            push;
  logic            pop;
  logic            spurious;
  logic            head_id;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            id_mem [DEPTH];

  // Full is judged on the registered count so a same-cycle pop cannot admit a push.
  assign full     = (outstanding == FULL_CNT);
  assign bus_req  = (inst_req | data_req) & ~full;
  assign hs       = bus_req & bus_addr_ok;
  assign push     = hs;
  // Only entries already queued may be returned; a return against an empty queue is dropped.
  assign pop      = bus_data_ok & (outstanding != '0);
  assign spurious = bus_data_ok & (outstanding == '0);
  assign head_id  = id_mem[rd_ptr];

  assign bus_cmd      = grant_data ? data_cmd : inst_cmd;
  assign inst_addr_ok = hs & ~grant_data;
  assign data_addr_ok = hs & grant_data;
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_data;

  // Tie-break favours whichever side lost the most recent handshake; data after reset.
  always_ff @(posedge clk) begin
    if (reset) rr_data <= 1'b1;
    else if (hs) rr_data <= ~grant_data;
  end

  assign tie_data = rr_data;
`else
  assign tie_data = 1'b1;
`endif

  // Grant state register: a pending request locks its grant until accepted.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  // Grant selection and lock transitions.
  always_comb begin
    state_nxt  = state;
    grant_data = data_req;
    case (state)
      IDLE: begin
        grant_data = (inst_req & data_req) ? tie_data : data_req;
        if (bus_req & ~bus_addr_ok) state_nxt = grant_data ? LOCK_D : LOCK_I;
      end
      LOCK_I: begin
        grant_data = 1'b0;
        if (hs) state_nxt = IDLE;
      end
      LOCK_D: begin
        grant_data = 1'b1;
        if (hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ID FIFO storage: records which side owns each accepted transaction.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant_data;
  end

  // FIFO pointers and outstanding count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky flag for data returns that arrive with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset) err_spurious <= 1'b0;
    else if (spurious) err_spurious <= 1'b1;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with queue-based reference model
module tb_sram_arbiter;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req, data_req, bus_addr_ok, bus_data_ok;
  logic [70:0]   inst_cmd, data_cmd, bus_cmd;
  logic [31:0]   bus_rdata, inst_rdata, data_rdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic          bus_req, err_spurious;
  logic [CW-1:0] outstanding;

  always #5 clk = ~clk;

  sram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_cmd(inst_cmd), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_cmd(data_cmd), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  typedef struct packed { logic side; logic [70:0] cmd; } hs_t;
  typedef struct packed { logic side; logic [31:0] rdata; } ret_t;

  hs_t  exp_hs[$];
  ret_t exp_ret[$];
  int   passes = 0;
  int   checks = 0;

  // Reference model: owner queue of accepted transactions, pending lock, tie preference.
  logic m_ids[$];
  int   m_lock;
  logic m_pref_data;
  logic m_err;
  logic m_last_hs;
  logic m_last_win;

  logic e_bus_req;
  logic e_win;
  int   e_out;
  logic e_err;
  logic check_en = 1'b0;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [70:0] rnd_cmd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[70:0];
  endfunction

  task automatic model_step();
    int   cnt;
    logic breq;
    logic win;
    ret_t r;
    hs_t  h;
    cnt       = m_ids.size();
    e_out     = cnt;
    e_err     = m_err;
    breq      = (inst_req || data_req) && (cnt < DEPTH);
    if (m_lock >= 0) win = (m_lock == 1);
    else if (inst_req && data_req) win = m_pref_data;
    else win = data_req;
    e_bus_req = breq;
    e_win     = win;
    if (bus_data_ok) begin
      if (cnt > 0) begin
        r.side  = m_ids.pop_front();
        r.rdata = bus_rdata;
        exp_ret.push_back(r);
      end else begin
        m_err = 1'b1;
      end
    end
    m_last_hs  = breq && bus_addr_ok;
    m_last_win = win;
    if (m_last_hs) begin
      h.side = win;
      h.cmd  = win ? data_cmd : inst_cmd;
      exp_hs.push_back(h);
      m_ids.push_back(win);
      m_lock = -1;
`ifdef ARB_ROUND_ROBIN_EN
      m_pref_data = !win;
`endif
    end else if (breq) begin
      m_lock = win ? 1 : 0;
    end
  endtask

  task automatic drive(input logic ir, input logic [70:0] ic, input logic dr, input logic [70:0] dc,
                       input logic bao, input logic bdo, input logic [31:0] rd);
    @(posedge clk); #1;
    inst_req = ir; inst_cmd = ic; data_req = dr; data_cmd = dc;
    bus_addr_ok = bao; bus_data_ok = bdo; bus_rdata = rd;
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    check_en = 1'b0;
    reset = 1'b1;
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ids.delete();
    m_lock = -1; m_pref_data = 1'b1; m_err = 1'b0;
    e_out = 0; e_err = 1'b0; e_bus_req = 1'b0; e_win = 1'b0;
    check_en = 1'b1;
  endtask

  // Monitor: per-cycle status compare plus scoreboard pops on every handshake/return.
  always @(negedge clk) begin
    if (check_en) begin
      chk("bus_req", 71'(bus_req), 71'(e_bus_req));
      if (e_bus_req) chk("bus_cmd", bus_cmd, e_win ? data_cmd : inst_cmd);
      chk("outstanding", 71'(outstanding), 71'(e_out));
      chk("err_spurious", 71'(err_spurious), 71'(e_err));
      if (inst_addr_ok || data_addr_ok) begin
        if (exp_hs.size() == 0) chk("unexpected_addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'(0));
        else begin
          hs_t h;
          h = exp_hs.pop_front();
          chk("addr_ok_side", 71'({inst_addr_ok, data_addr_ok}), h.side ? 71'(1) : 71'(2));
          chk("hs_cmd", bus_cmd, h.cmd);
        end
      end
      if (exp_hs.size() != 0) begin
        chk("missing_addr_ok", 71'(0), 71'(exp_hs.size()));
        exp_hs.delete();
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_ret.size() == 0) chk("unexpected_data_ok", 71'({inst_data_ok, data_data_ok}), 71'(0));
        else begin
          ret_t r;
          r = exp_ret.pop_front();
          chk("data_ok_side", 71'({inst_data_ok, data_data_ok}), r.side ? 71'(1) : 71'(2));
          chk("rdata", 71'(r.side ? data_rdata : inst_rdata), 71'(r.rdata));
        end
      end
      if (exp_ret.size() != 0) begin
        chk("missing_data_ok", 71'(0), 71'(exp_ret.size()));
        exp_ret.delete();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ip, dp;
    logic [70:0] ic, dc;
    logic        bdo;
    reset = 1'b1;
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    inst_cmd = '0; data_cmd = '0; bus_rdata = '0;
    do_reset();

    // Tie on two consecutive cycles.
    drive(1, rnd_cmd(), 1, rnd_cmd(), 1, 0, 0);
    drive(1, inst_cmd, 1, rnd_cmd(), 1, 0, 0);
    drive(0, '0, 0, '0, 0, 1, 32'h11);
    drive(0, '0, 0, '0, 0, 1, 32'h22);

    // Inst locked for three cycles, then data joins.
    ic = rnd_cmd(); dc = rnd_cmd();
    repeat (3) drive(1, ic, 0, '0, 0, 0, 0);
    drive(1, ic, 1, dc, 0, 0, 0);
    drive(1, ic, 1, dc, 1, 0, 0);
    drive(0, '0, 1, dc, 1, 0, 0);
    drive(0, '0, 0, '0, 0, 1, 32'h33);
    drive(0, '0, 0, '0, 0, 1, 32'h44);

    // Order I,D,D,I then returns 1..4.
    drive(1, rnd_cmd(), 0, '0, 1, 0, 0);
    drive(0, '0, 1, rnd_cmd(), 1, 0, 0);
    drive(0, '0, 1, rnd_cmd(), 1, 0, 0);
    drive(1, rnd_cmd(), 0, '0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) drive(0, '0, 0, '0, 0, 1, 32'(i));

    // Full queue with a same-cycle return: no handshake until the next cycle.
    for (int i = 0; i < DEPTH; i++) drive(1, rnd_cmd(), 0, '0, 1, 0, 0);
    ic = rnd_cmd();
    drive(1, ic, 0, '0, 1, 1, 32'h55);
    drive(1, ic, 0, '0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 0, '0, 0, 1, $urandom);

    // Spurious return with nothing outstanding.
    drive(0, '0, 0, '0, 0, 1, 32'h66);
    drive(0, '0, 0, '0, 0, 0, 0);

    // Reset mid-transaction discards queued IDs.
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, '0, 1, rnd_cmd(), 1, 0, 0);
    do_reset();
    drive(0, '0, 0, '0, 0, 1, 32'h77);
    drive(0, '0, 0, '0, 0, 0, 0);

    // Randomized traffic honouring the hold-until-accepted protocol.
    do_reset();
    ip = 0; dp = 0; ic = '0; dc = '0;
    for (int n = 0; n < 600; n++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; ic = rnd_cmd(); end
      if (!dp && $urandom_range(0, 2) == 0) begin dp = 1; dc = rnd_cmd(); end
      bdo = (m_ids.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
      drive(ip, ic, dp, dc, 1'($urandom_range(0, 1)), bdo, $urandom);
      if (m_last_hs) begin
        if (m_last_win) dp = 0;
        else ip = 0;
      end
    end
    while (m_ids.size() > 0) drive(0, '0, 0, '0, 0, 1, $urandom);
    drive(0, '0, 0, '0, 0, 0, 0);
    drive(0, '0, 0, '0, 0, 0, 0);

    @(posedge clk); #1;
    check_en = 1'b0;
    chk("queues_drained", 71'(exp_hs.size() + exp_ret.size()), 71'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
